// File: rtl/wb_pkg.sv
// Shared types and default widths for the register-file writeback arbiter.
package wb_pkg;

  localparam int WB_DATA_W     = 24;
  localparam int WB_REG_ADDR_W = 4;

  typedef struct packed {
    logic [WB_REG_ADDR_W-1:0] dest;
    logic [WB_DATA_W-1:0]     data;
  } wb_req_t;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_ALU  = 2'd1,
    WB_SRC_MEM  = 2'd2
  } wb_src_e;

endpackage

// File: rtl/wb_starve_counter.sv
// Counts consecutive cycles a waiting requester is denied; raises force_alu at MAX_WAIT.
// Zero latency on force_alu (combinational from count and waiting); no backpressure of its own.
module wb_starve_counter #(
  parameter int MAX_WAIT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic granted,
  input  logic flush,
  output logic force_alu
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (flush || !waiting || granted) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != CNT_MAX) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign force_alu = waiting && (wait_cnt_q == CNT_MAX);

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between load data (priority) and ALU results (anti-starvation).
// One-cycle registered write; readies are combinational from valid and starvation state, never from ready.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W     = WB_DATA_W,
  parameter int REG_ADDR_W = WB_REG_ADDR_W,
  parameter int MAX_WAIT   = 3,
  parameter int PERF_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic [PERF_W-1:0]     conflict_cnt
);

  logic                  force_alu;
  logic                  alu_rdy;
  logic                  mem_rdy;
  wb_src_e               src;

  logic                  rf_we_q,    rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]     rf_wdata_q, rf_wdata_d;
  logic [PERF_W-1:0]     conflict_cnt_q, conflict_cnt_d;

  wb_starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk       (clk),
    .rst_n     (rst_n),
    .waiting   (alu_valid),
    .granted   (alu_rdy),
    .flush     (flush),
    .force_alu (force_alu)
  );

  // Readies are held low during reset so no source sees a phantom acceptance.
  always_comb begin
    mem_rdy = 1'b0;
    alu_rdy = 1'b0;
    if (rst_n && !flush) begin
      mem_rdy = mem_valid && !force_alu;
      alu_rdy = alu_valid && !mem_rdy;
    end
  end

  always_comb begin
    src = WB_SRC_NONE;
    if (mem_rdy) begin
      src = WB_SRC_MEM;
    end else if (alu_rdy) begin
      src = WB_SRC_ALU;
    end
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    case (src)
      WB_SRC_MEM: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = mem_dest;
        rf_wdata_d = mem_data;
      end
      WB_SRC_ALU: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = alu_dest;
        rf_wdata_d = alu_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (alu_valid && mem_valid && !flush && (conflict_cnt_q != {PERF_W{1'b1}})) begin
      conflict_cnt_d = conflict_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      conflict_cnt_q <= '0;
    end else begin
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign alu_ready    = alu_rdy;
  assign mem_ready    = mem_rdy;
  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: scoreboard of expected register-file writes plus
// directed grant-order and counter checks.
module tb_wb_port_arbiter;
  import wb_pkg::*;

  localparam int DATA_W     = WB_DATA_W;
  localparam int REG_ADDR_W = WB_REG_ADDR_W;
  localparam int MAX_WAIT   = 3;
  localparam int PERF_W     = 4;

  typedef struct packed {
    logic    we;
    wb_req_t req;
  } exp_wr_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  flush = 1'b0;
  logic                  alu_valid = 1'b0;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_dest = '0;
  logic [DATA_W-1:0]     alu_data = '0;
  logic                  mem_valid = 1'b0;
  logic                  mem_ready;
  logic [REG_ADDR_W-1:0] mem_dest = '0;
  logic [DATA_W-1:0]     mem_data = '0;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
  logic [PERF_W-1:0]     conflict_cnt;

  int checks = 0;
  int errors = 0;

  exp_wr_t exp_q[$];
  int      m_wait;
  int      m_conf;
  wb_req_t m_last;

  wb_port_arbiter #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W),
    .MAX_WAIT   (MAX_WAIT),
    .PERF_W     (PERF_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_dest     (alu_dest),
    .alu_data     (alu_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_dest     (mem_dest),
    .mem_data     (mem_data),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    m_wait = 0;
    m_conf = 0;
    m_last = '0;
    exp_q.delete();
  endtask

  // Reset pulse starting just after a rising edge; checks outputs while held.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_rf_we"}, 32'(rf_we), 32'd0);
    check({tag, "_rdy"}, {30'd0, alu_ready, mem_ready}, 32'd0);
    check({tag, "_conf"}, 32'(conflict_cnt), 32'd0);
    check({tag, "_waddr"}, 32'(rf_waddr), 32'd0);
    check({tag, "_wdata"}, 32'(rf_wdata), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_rf_we_edge"}, 32'(rf_we), 32'd0);
    rst_n = 1'b1;
    model_clear();
  endtask

  // One clock of stimulus: inputs are already set; exp_src < 0 means no directed grant check.
  task automatic drive_cycle(input string tag, input logic fl, input int exp_src);
    logic    m_force, m_mem, m_alu;
    exp_wr_t e;
    exp_wr_t got;
    flush = fl;
    #2;
    m_force = alu_valid && (m_wait == MAX_WAIT);
    m_mem   = !fl && mem_valid && !m_force;
    m_alu   = !fl && alu_valid && !m_mem;
    check({tag, "_mem_ready"}, 32'(mem_ready), 32'(m_mem));
    check({tag, "_alu_ready"}, 32'(alu_ready), 32'(m_alu));
    if (exp_src >= 0) begin
      check({tag, "_grant"}, mem_ready ? 32'd2 : (alu_ready ? 32'd1 : 32'd0), 32'(exp_src));
    end
    e.we       = m_mem || m_alu;
    e.req.dest = m_mem ? mem_dest : alu_dest;
    e.req.data = m_mem ? mem_data : alu_data;
    exp_q.push_back(e);
    if (alu_valid && mem_valid && !fl && m_conf != (1 << PERF_W) - 1) m_conf++;
    if (fl || !alu_valid || m_alu) m_wait = 0;
    else if (m_wait < MAX_WAIT) m_wait++;
    @(posedge clk);
    #1;
    flush = 1'b0;
    got = exp_q.pop_front();
    if (got.we) m_last = got.req;
    check({tag, "_rf_we"}, 32'(rf_we), 32'(got.we));
    check({tag, "_rf_waddr"}, 32'(rf_waddr), 32'(m_last.dest));
    check({tag, "_rf_wdata"}, 32'(rf_wdata), 32'(m_last.data));
    check({tag, "_conflict"}, 32'(conflict_cnt), 32'(m_conf));
  endtask

  int exp_seq[8] = '{2, 2, 2, 1, 2, 2, 2, 1};

  initial begin
    model_clear();
    // Reset state at time zero.
    #1;
    check("por_rf_we", 32'(rf_we), 32'd0);
    check("por_rdy", {30'd0, alu_ready, mem_ready}, 32'd0);
    check("por_conf", 32'(conflict_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ALU only, four back-to-back writes.
    alu_valid = 1'b1;
    alu_dest  = 4'd3;
    alu_data  = 24'h00ABCD;
    for (int i = 0; i < 4; i++) drive_cycle("alu_only", 1'b0, 1);
    check("alu_only_last_data", 32'(rf_wdata), 32'h00ABCD);

    // Reset mid-grant: alu_valid still high, in-flight write discarded.
    do_reset("rst_mid");
    alu_valid = 1'b0;

    // Contention: memory wins three times, then the ALU is forced through.
    alu_valid = 1'b1;
    alu_dest  = 4'd7;
    alu_data  = 24'hA00000;
    mem_valid = 1'b1;
    mem_dest  = 4'd9;
    mem_data  = 24'h000100;
    for (int i = 0; i < 8; i++) begin
      drive_cycle("contend", 1'b0, exp_seq[i]);
      if (exp_seq[i] == 2) mem_data = mem_data + 24'd1;
      else alu_data = alu_data + 24'd1;
    end
    check("contend_conflict8", 32'(conflict_cnt), 32'd8);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    @(posedge clk);
    #1;
    do_reset("rst_t4");

    // Same destination from both sources: load first, then ALU overwrites.
    mem_valid = 1'b1;
    mem_dest  = 4'd5;
    mem_data  = 24'h000111;
    alu_valid = 1'b1;
    alu_dest  = 4'd5;
    alu_data  = 24'h000222;
    drive_cycle("same_dest_mem", 1'b0, 2);
    check("same_dest_first", 32'(rf_wdata), 32'h000111);
    mem_valid = 1'b0;
    drive_cycle("same_dest_alu", 1'b0, 1);
    check("same_dest_second", 32'(rf_wdata), 32'h000222);
    check("same_dest_addr", 32'(rf_waddr), 32'd5);
    alu_valid = 1'b0;
    @(posedge clk);
    #1;
    do_reset("rst_t5");

    // Flush after two denials restarts the starvation count.
    alu_valid = 1'b1;
    alu_dest  = 4'd2;
    alu_data  = 24'h0A0A0A;
    mem_valid = 1'b1;
    mem_dest  = 4'd4;
    mem_data  = 24'h0B0B0B;
    drive_cycle("flush_pre", 1'b0, 2);
    drive_cycle("flush_pre", 1'b0, 2);
    drive_cycle("flush_cyc", 1'b1, 0);
    check("flush_no_write", 32'(rf_we), 32'd0);
    check("flush_conf_hold", 32'(conflict_cnt), 32'd2);
    for (int i = 0; i < 4; i++) drive_cycle("flush_post", 1'b0, exp_seq[i]);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    @(posedge clk);
    #1;
    do_reset("rst_t6");

    // Conflict counter saturation with a 4-bit counter.
    alu_valid = 1'b1;
    mem_valid = 1'b1;
    for (int i = 0; i < 20; i++) drive_cycle("sat", 1'b0, -1);
    check("sat_hold_f", 32'(conflict_cnt), 32'hF);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    drive_cycle("idle", 1'b0, 0);
    check("sat_idle_f", 32'(conflict_cnt), 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
